pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage ARM-subset pipeline around the execute stage.
//  - Detects RAW hazards on ID sources, and selects forwarding for both ALU operands.
//  - Handles the branch flush.
//  - Freezes the pipe while a data-memory access waits on a slow memory.
//  - Owns the architectural status register (NZCV) that feeds the ALU carry-in.

---
 rtl/pipe_ctrl_pkg.sv | 7 +
 rtl/hazard_fwd_unit.sv | 31 +++
 rtl/pipeline_hazard_controller.sv | 90 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control state type and operand forward-select codes
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational RAW match, load-use/any-RAW hazard and ALU operand forward select
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       src1_vld,
  input  logic       two_src,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hazard,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2
);
  logic e1, e2, m1, m2;
  always_comb begin
    e1 = src1_vld & exe_wb_en & (src1 == exe_dest);
    e2 = two_src & exe_wb_en & (src2 == exe_dest);
    m1 = src1_vld & mem_wb_en & (src1 == mem_dest);
    m2 = two_src & mem_wb_en & (src2 == mem_dest);
    hazard = FORWARD_EN ? exe_mem_r_en & (e1 | e2) : e1 | e2 | m1 | m2;
    // a load result is not available in EXE, so that match stalls rather than forwards
    fwd_sel1 = !FORWARD_EN ? FWD_REG : e1 ? (exe_mem_r_en ? FWD_REG : FWD_EXE) : m1 ? FWD_MEM : FWD_REG;
    fwd_sel2 = !FORWARD_EN ? FWD_REG : e2 ? (exe_mem_r_en ? FWD_REG : FWD_EXE) : m2 ? FWD_MEM : FWD_REG;
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/forward sequencing, memory-wait FSM and NZCV status register
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN  = 1'b1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_src1_vld,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             exe_s,
  input  logic [3:0]       alu_status,
  output logic [3:0]       sr,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_back,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_t        state;
  logic [TW-1:0] to_cnt;
  logic          hazard, fb, stall, bflush, frz, fault;
  logic [1:0]    sel1, sel2;
  hazard_fwd_unit #(.FORWARD_EN(FORWARD_EN)) u_hfu (
    .src1(id_src1), .src2(id_src2), .src1_vld(id_src1_vld), .two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .hazard(hazard), .fwd_sel1(sel1), .fwd_sel2(sel2)
  );
  // a memory wait holds the whole pipe, so front-end freezes follow freeze_back too
  always_comb begin
    fault = (state == FAULT);
    fb = (state == RUN) ? (mem_req & !mem_ready) : ((state == MEM_WAIT) & !mem_ready);
    stall = hazard & !fb & !branch_taken;
    bflush = branch_taken & !fb & !fault;
    frz = fault | fb | stall;
    freeze_pc = rst_n & frz;
    freeze_if_id = rst_n & frz;
    flush_if_id = rst_n & bflush;
    flush_id_exe = rst_n & (fault | bflush | stall);
    freeze_back = rst_n & fb;
    fwd_sel1 = rst_n ? sel1 : FWD_REG;
    fwd_sel2 = rst_n ? sel2 : FWD_REG;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      to_cnt <= '0;
      mem_fault <= 1'b0;
      sr <= 4'b0000;
      stall_cnt <= '0;
    end else begin
      if (exe_s & !fb & !fault) sr <= alu_status;
      if (frz & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: if (mem_req & !mem_ready) begin
          state <= MEM_WAIT;
          to_cnt <= '0;
        end
        MEM_WAIT: if (mem_ready) begin
          state <= RUN;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
          if (to_cnt == TW'(MEM_TIMEOUT - 1)) begin
            state <= FAULT;
            mem_fault <= 1'b1;
          end
        end
        default: state <= FAULT;
      endcase
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed + random stimulus, queued reference expectations, negedge monitor
module tb_pipeline_hazard_controller;
  localparam bit FE = 1'b1;
  localparam int TO = 4;
  localparam int CW = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest, alu_status;
  logic id_two_src, id_src1_vld, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, mem_ready, branch_taken, exe_s;
  logic [3:0] sr;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back, mem_fault;
  logic [CW-1:0] stall_cnt;
  typedef struct packed {
    logic [3:0] sr; logic [1:0] f1, f2;
    logic fpc, fif, flif, flie, fb, mf;
    logic [CW-1:0] sc;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit m_wait, m_fault;
  int m_cnt, m_stall;
  logic [3:0] m_sr;
  pipeline_hazard_controller #(.FORWARD_EN(FE), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_src1_vld(id_src1_vld), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .exe_s(exe_s), .alu_status(alu_status), .sr(sr),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe), .freeze_back(freeze_back),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic idle();
    {id_src1, id_src2, exe_dest, mem_dest, alu_status} = '0;
    {id_two_src, id_src1_vld, exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, branch_taken, exe_s} = '0;
    mem_ready = 1'b1;
  endtask
  task automatic rnd();
    id_src1 = 4'($urandom_range(0, 3));
    id_src2 = 4'($urandom_range(0, 3));
    exe_dest = 4'($urandom_range(0, 3));
    mem_dest = 4'($urandom_range(0, 3));
    {id_two_src, id_src1_vld, exe_wb_en, exe_mem_r_en, mem_wb_en, exe_s} = 6'($urandom);
    mem_req = ($urandom_range(0, 3) == 0);
    mem_ready = ($urandom_range(0, 2) != 0);
    branch_taken = ($urandom_range(0, 7) == 0);
    alu_status = 4'($urandom);
    rst_n = ($urandom_range(0, 199) != 0);
  endtask
  // expected outputs for the inputs now applied, then advance the model across the next edge
  task automatic cycle();
    exp_t e;
    bit e1, e2, m1, m2, hz, fb, stl, bfl, frz;
    int s1, s2;
    if (!rst_n) begin m_wait = 0; m_fault = 0; m_cnt = 0; m_sr = 0; m_stall = 0; end
    e1 = id_src1_vld && exe_wb_en && id_src1 == exe_dest;
    e2 = id_two_src && exe_wb_en && id_src2 == exe_dest;
    m1 = id_src1_vld && mem_wb_en && id_src1 == mem_dest;
    m2 = id_two_src && mem_wb_en && id_src2 == mem_dest;
    hz = FE ? exe_mem_r_en && (e1 || e2) : (e1 || e2 || m1 || m2);
    s1 = !FE ? 0 : e1 ? (exe_mem_r_en ? 0 : 1) : m1 ? 2 : 0;
    s2 = !FE ? 0 : e2 ? (exe_mem_r_en ? 0 : 1) : m2 ? 2 : 0;
    fb = m_fault ? 0 : m_wait ? !mem_ready : (mem_req && !mem_ready);
    stl = hz && !fb && !branch_taken;
    bfl = branch_taken && !fb && !m_fault;
    frz = m_fault || fb || stl;
    e = '{sr: m_sr, f1: 2'(s1), f2: 2'(s2), fpc: frz, fif: frz, flif: bfl,
          flie: m_fault || bfl || stl, fb: fb, mf: m_fault, sc: CW'(m_stall)};
    if (!rst_n) e = '0;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (exe_s && !fb && !m_fault) m_sr = alu_status;
      if (frz && m_stall < 2 ** CW - 1) m_stall++;
      if (m_wait) begin
        if (mem_ready) begin m_wait = 0; m_cnt = 0; end
        else if (++m_cnt == TO) begin m_wait = 0; m_fault = 1; end
      end else if (!m_fault && mem_req && !mem_ready) begin
        m_wait = 1; m_cnt = 0;
      end
    end
  endtask
  exp_t act, exq;
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exq = q.pop_front();
      act = {sr, fwd_sel1, fwd_sel2, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe,
             freeze_back, mem_fault, stall_cnt};
      vectors++;
      if (act !== exq) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got sr=%h f1=%0d f2=%0d fpc=%b fif=%b flif=%b flie=%b fb=%b mf=%b sc=%0d exp sr=%h f1=%0d f2=%0d fpc=%b fif=%b flif=%b flie=%b fb=%b mf=%b sc=%0d",
          cyc, act.sr, act.f1, act.f2, act.fpc, act.fif, act.flif, act.flie, act.fb, act.mf, act.sc,
          exq.sr, exq.f1, exq.f2, exq.fpc, exq.fif, exq.flif, exq.flie, exq.fb, exq.mf, exq.sc);
      end
    end
  end
  initial begin
    idle();
    @(posedge clk);
    #1;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    exe_dest = 4'd1; exe_wb_en = 1; id_src1 = 4'd1; id_src1_vld = 1;
    cycle();
    idle(); exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 4'd3; id_src1_vld = 1;
    id_src2 = 4'd3; id_two_src = 1;
    cycle();
    exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 4'd3; mem_wb_en = 1;
    cycle();
    idle(); exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; id_src1 = 4'd3; id_src1_vld = 1; branch_taken = 1;
    cycle();
    idle(); exe_s = 1; alu_status = 4'hF; mem_req = 1; mem_ready = 0; branch_taken = 1;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    idle(); exe_s = 1; alu_status = 4'b0110;
    cycle();
    exe_s = 0; alu_status = 4'b1001;
    repeat (2) cycle();
    idle(); mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (12) cycle();
    exe_s = 1; alu_status = 4'hA; mem_ready = 1; mem_req = 0;
    repeat (60) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; idle();
    cycle();
    for (int i = 0; i < 1500; i++) begin
      rnd();
      cycle();
    end
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
